// File: rtl/spi_pkg.sv
// spi_pkg: shared widths, fifo word layout and drain FSM states for the SPI slave receive path
package spi_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int LAST_BIT = DATA_W_DEF;
    typedef enum logic {IDLE, FETCH} drain_st_e;
endpackage

// File: rtl/spi_sync.sv
// spi_sync: multi-flop synchroniser for one asynchronous pin with edge strobes on the synced value
module spi_sync #(
    parameter int STAGES = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync_q, sync_d;
    logic prev_q, prev_d;

    // shift the pin through the chain and remember the last synced sample for edge detection
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
        prev_d = sync_q[STAGES-1];
    end

    // reset fills the chain with the idle level so no false edge appears at release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign q = sync_q[STAGES-1];
    assign rise = q & ~prev_q;
    assign fall = ~q & prev_q;
endmodule

// File: rtl/spi_rx_ctrl.sv
// spi_rx_ctrl: deserialises SPI MOSI into bytes, stages them into the rx FIFO with a frame-end flag and drains the FIFO onto AXI-Stream
module spi_rx_ctrl
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              axi_aclk,
    input  logic              axi_aresetn,
    input  logic              spi_clk,
    input  logic              spi_mosi,
    input  logic              spi_cs,
    output logic              fifo_wr_en,
    output logic [DATA_W:0]   fifo_wdata,
    input  logic              fifo_full,
    output logic              fifo_rd_en,
    input  logic [DATA_W:0]   fifo_rdata,
    input  logic              fifo_empty,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tlast,
    input  logic              err_clr,
    output logic              overflow_err,
    output logic              frame_err
);
    localparam int CW = $clog2(DATA_W);
    localparam int LAST = LAST_BIT + DATA_W - DATA_W_DEF;
    localparam logic [CW-1:0] LAST_IDX = CW'(DATA_W - 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic cs_s, cs_rise, cs_fall;
    logic unused_sync;

    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(axi_aclk), .rst_n(axi_aresetn), .d(spi_clk),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .clk(axi_aclk), .rst_n(axi_aresetn), .d(spi_mosi),
        .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall)
    );
    spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .clk(axi_aclk), .rst_n(axi_aresetn), .d(spi_cs),
        .q(cs_s), .rise(cs_rise), .fall(cs_fall)
    );

    assign unused_sync = ^{sclk_s, sclk_fall, mosi_rise, mosi_fall};

    logic [CW-1:0]     bit_cnt_q, bit_cnt_d, bit_base;
    logic [DATA_W-2:0] shreg_q, shreg_d;
    logic [DATA_W-1:0] stg_q, stg_d, word_new;
    logic              stg_vld_q, stg_vld_d;
    logic              active_q, active_d;
    logic              armed_q, armed_d;
    logic              wr_en_q, wr_en_d;
    logic [DATA_W:0]   wdata_q, wdata_d, wr_word;
    logic              ovf_q, ovf_d, ferr_q, ferr_d;
    logic              frame_end, sclk_edge, wr_req, ferr_set;
    drain_st_e         state_q, state_d;
    logic              tvalid_q, tvalid_d, tlast_q, tlast_d, rd_req;
    logic [DATA_W-1:0] tdata_q, tdata_d;

    // deserialise bits, hold the newest word until its frame position is known, and emit FIFO writes
    always_comb begin
        active_d = active_q;
        armed_d = armed_q;
        bit_cnt_d = bit_cnt_q;
        shreg_d = shreg_q;
        stg_d = stg_q;
        stg_vld_d = stg_vld_q;
        wr_req = 1'b0;
        wr_word = '0;
        ferr_set = 1'b0;
        frame_end = cs_rise & active_q;
        sclk_edge = sclk_rise & ~cs_s & (active_q | cs_fall);
        bit_base = cs_fall ? '0 : bit_cnt_q;
        word_new = {shreg_q, mosi_s};
        if (cs_fall) begin
            active_d = 1'b1;
            armed_d = 1'b1;
            bit_cnt_d = '0;
        end
        if (sclk_edge) begin
            shreg_d = word_new[DATA_W-2:0];
            bit_cnt_d = (bit_base == LAST_IDX) ? '0 : bit_base + 1'b1;
            if (bit_base == LAST_IDX) begin
                stg_d = word_new;
                stg_vld_d = 1'b1;
                wr_req = stg_vld_q;
                wr_word = {1'b0, stg_q};
            end
        end
        if (frame_end) begin
            active_d = 1'b0;
            bit_cnt_d = '0;
            stg_vld_d = 1'b0;
            ferr_set = (bit_cnt_q != '0);
            wr_req = stg_vld_q;
            wr_word = {1'b1, stg_q};
        end
        wr_en_d = wr_req & ~fifo_full;
        wdata_d = wr_req ? wr_word : wdata_q;
        ovf_d = (wr_req & fifo_full) | (ovf_q & ~err_clr);
        ferr_d = ferr_set | (ferr_q & ~err_clr);
    end

    // receive-side state and sticky error flags
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            active_q <= 1'b0;
            armed_q <= 1'b0;
            bit_cnt_q <= '0;
            shreg_q <= '0;
            stg_q <= '0;
            stg_vld_q <= 1'b0;
            wr_en_q <= 1'b0;
            wdata_q <= '0;
            ovf_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            active_q <= active_d;
            armed_q <= armed_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q <= shreg_d;
            stg_q <= stg_d;
            stg_vld_q <= stg_vld_d;
            wr_en_q <= wr_en_d;
            wdata_q <= wdata_d;
            ovf_q <= ovf_d;
            ferr_q <= ferr_d;
        end
    end

    // issue one FIFO read when the output register will be free, load the returned word a cycle later
    always_comb begin
        rd_req = (state_q == IDLE) & armed_q & ~fifo_empty & (~tvalid_q | m_axis_tready);
        state_d = rd_req ? FETCH : IDLE;
        tvalid_d = (state_q == FETCH) | (tvalid_q & ~m_axis_tready);
        tdata_d = (state_q == FETCH) ? fifo_rdata[DATA_W-1:0] : tdata_q;
        tlast_d = (state_q == FETCH) ? fifo_rdata[LAST] : tlast_q;
    end

    // drain FSM and registered stream outputs
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= IDLE;
            tvalid_q <= 1'b0;
            tdata_q <= '0;
            tlast_q <= 1'b0;
        end else begin
            state_q <= state_d;
            tvalid_q <= tvalid_d;
            tdata_q <= tdata_d;
            tlast_q <= tlast_d;
        end
    end

    assign fifo_wr_en = wr_en_q;
    assign fifo_wdata = wdata_q;
    assign fifo_rd_en = rd_req;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata = tdata_q;
    assign m_axis_tlast = tlast_q;
    assign overflow_err = ovf_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_spi_rx_ctrl.sv
// tb_spi_rx_ctrl: scoreboard bench driving SPI frames and checking FIFO traffic, stream beats and error flags
module tb_spi_rx_ctrl;
    logic clk = 0, rstn = 0, sclk = 0, mosi = 0, cs = 1, err_clr = 0, tready = 0, force_full = 0;
    logic fifo_wr_en, fifo_rd_en, fifo_empty, fifo_full, tvalid, tlast, ovf, ferr;
    logic [8:0] fifo_wdata;
    logic [8:0] fifo_rdata = '0;
    logic [7:0] tdata;
    int checks = 0, errors = 0;
    int fcnt = 0, wr_count = 0, w_start = 0, exp_writes = 0;
    int ready_mode = 0;
    bit exp_ovf = 0, exp_ferr = 0;
    logic [8:0] exp_q[$];
    logic [8:0] fq[$];
    logic [7:0] tx[$];
    logic [8:0] e;
    logic [7:0] prev_data;
    logic prev_last;
    bit prev_pending = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (fcnt == 0);
    assign fifo_full = force_full | (fcnt >= 16);

    spi_rx_ctrl dut (
        .axi_aclk(clk), .axi_aresetn(rstn), .spi_clk(sclk), .spi_mosi(mosi), .spi_cs(cs),
        .fifo_wr_en(fifo_wr_en), .fifo_wdata(fifo_wdata), .fifo_full(fifo_full),
        .fifo_rd_en(fifo_rd_en), .fifo_rdata(fifo_rdata), .fifo_empty(fifo_empty),
        .m_axis_tvalid(tvalid), .m_axis_tready(tready), .m_axis_tdata(tdata), .m_axis_tlast(tlast),
        .err_clr(err_clr), .overflow_err(ovf), .frame_err(ferr)
    );

    // behavioural rx FIFO: read data appears the cycle after the read strobe
    always @(posedge clk) begin
        if (!rstn) begin
            fq.delete();
            fcnt <= 0;
        end else begin
            if (fifo_rd_en && fq.size() > 0) fifo_rdata <= fq.pop_front();
            if (fifo_wr_en) begin
                wr_count <= wr_count + 1;
                if (fq.size() < 16) fq.push_back(fifo_wdata);
            end
            fcnt <= fq.size();
        end
    end

    // stream monitor: drives tready, checks stability while stalled and pops the scoreboard on handshake
    always @(negedge clk) begin
        if (!rstn) begin
            tready = 0;
            prev_pending = 0;
        end else begin
            if (prev_pending) begin
                checks++;
                if (!tvalid || tdata !== prev_data || tlast !== prev_last) begin
                    errors++;
                    $display("FAIL stall_stable: got v=%0b d=%0h l=%0b expected v=1 d=%0h l=%0b", tvalid, tdata, tlast, prev_data, prev_last);
                end
            end
            tready = (ready_mode == 0) ? 1'b1 : (ready_mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
            if (tvalid && tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat: got unexpected %0h expected none", {tlast, tdata});
                end else begin
                    e = exp_q.pop_front();
                    if ({tlast, tdata} !== e) begin
                        errors++;
                        $display("FAIL beat: got %0h expected %0h", {tlast, tdata}, e);
                    end
                end
                prev_pending = 0;
            end else begin
                prev_pending = tvalid;
                prev_data = tdata;
                prev_last = tlast;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input bit b, input bit f);
        mosi = b;
        force_full = f;
        tick(4);
        sclk = 1;
        tick(4);
        sclk = 0;
        force_full = 0;
    endtask

    // reference model: every complete byte reaches the stream, the last complete one tagged tlast,
    // except a byte whose write coincides with the completion of the following byte under a forced-full window
    task automatic run_frame(input int extra_bits, input logic [7:0] extra_val, input int full_bit);
        bit bits[$];
        int nb = tx.size();
        int drops = 0;
        w_start = wr_count;
        foreach (tx[k]) for (int i = 7; i >= 0; i--) bits.push_back(tx[k][i]);
        for (int i = 0; i < extra_bits; i++) bits.push_back(extra_val[7-i]);
        for (int k = 0; k < nb; k++) begin
            if (k < nb - 1 && full_bit == 8 * (k + 1) + 7) drops++;
            else exp_q.push_back({(k == nb - 1) ? 1'b1 : 1'b0, tx[k]});
        end
        exp_writes = nb - drops;
        if (drops > 0) exp_ovf = 1;
        if (extra_bits > 0) exp_ferr = 1;
        cs = 0;
        tick(6);
        foreach (bits[i]) send_bit(bits[i], i == full_bit);
        tick(4);
        cs = 1;
        tick(8);
    endtask

    task automatic check_frame(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick(1);
        chk({tag, "_drain"}, exp_q.size(), 0);
        chk({tag, "_writes"}, wr_count - w_start, exp_writes);
        chk({tag, "_overflow_err"}, ovf, exp_ovf);
        chk({tag, "_frame_err"}, ferr, exp_ferr);
    endtask

    task automatic clr_err(input string tag);
        err_clr = 1;
        tick(1);
        err_clr = 0;
        tick(1);
        exp_ovf = 0;
        exp_ferr = 0;
        chk({tag, "_ovf_cleared"}, ovf, 0);
        chk({tag, "_ferr_cleared"}, ferr, 0);
    endtask

    initial begin
        int n, xb, fb, w0;
        tick(3);
        chk("rst_wr_en", fifo_wr_en, 0);
        chk("rst_wdata", fifo_wdata, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tdata", tdata, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_errs", {ovf, ferr}, 0);
        rstn = 1;
        tick(4);

        tx.delete(); tx.push_back(8'hA5); tx.push_back(8'h3C);
        run_frame(0, 8'h00, -1);
        check_frame("two_byte");

        ready_mode = 2;
        tx.delete(); tx.push_back(8'h81);
        run_frame(0, 8'h00, -1);
        for (int i = 0; i < 200 && !tvalid; i++) tick(1);
        tick(20);
        chk("stall_tvalid", tvalid, 1);
        chk("stall_tdata", tdata, 8'h81);
        chk("stall_tlast", tlast, 1);
        ready_mode = 0;
        check_frame("single_stall");

        tx.delete(); tx.push_back(8'hF0);
        run_frame(4, 8'hA0, -1);
        check_frame("partial");
        clr_err("partial");

        tx.delete(); tx.push_back(8'h11); tx.push_back(8'h22); tx.push_back(8'h33);
        run_frame(0, 8'h00, 23);
        check_frame("overflow");
        clr_err("overflow");

        cs = 0;
        tick(6);
        for (int i = 0; i < 5; i++) send_bit(i[0], 0);
        rstn = 0;
        tick(2);
        chk("midrst_tvalid", tvalid, 0);
        chk("midrst_wr_en", fifo_wr_en, 0);
        chk("midrst_errs", {ovf, ferr}, 0);
        cs = 1;
        tick(4);
        rstn = 1;
        tick(6);
        tx.delete(); tx.push_back(8'h55);
        run_frame(0, 8'h00, -1);
        check_frame("after_reset");

        w0 = wr_count;
        repeat (3) begin
            cs = 0; tick(10);
            cs = 1; tick(10);
        end
        tick(20);
        chk("cs_only_writes", wr_count - w0, 0);
        chk("cs_only_errs", {ovf, ferr}, 0);
        chk("cs_only_tvalid", tvalid, 0);

        ready_mode = 1;
        for (int r = 0; r < 8; r++) begin
            tx.delete();
            n = $urandom_range(1, 4);
            repeat (n) tx.push_back(8'($urandom));
            xb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
            fb = (n > 1 && $urandom_range(0, 2) == 0) ? 8 * $urandom_range(1, n - 1) + 7 : -1;
            run_frame(xb, 8'($urandom), fb);
            check_frame("rand");
            if (exp_ovf || exp_ferr) clr_err("rand");
        end
        ready_mode = 0;
        tick(10);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_rx_ctrl.md
Name: spi_rx_ctrl

Overview:
Sequencer for the SPI-slave receive path. It oversamples the external SPI pins in the axi_aclk domain and deserialises MOSI into bytes. Completed bytes are written, each with a frame-end flag, into the external rx buffer FIFO. The block then drains that FIFO onto an AXI4-Stream master, asserting tlast on the final byte of each chip-select frame. It sits between the SPI pins and the SPI-to-DAC stream, and owns both FIFO ports.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on spi_clk, spi_mosi and spi_cs (minimum 2).
DATA_W, 8, bits per SPI word and per tdata beat.

Ports:
axi_aclk  in  1  single system clock; all logic is on its rising edge.
axi_aresetn  in  1  asynchronous, active-low reset.
spi_clk  in  1  SPI SCLK, asynchronous to axi_aclk; mode 0, sampled on its rising edge.
spi_mosi  in  1  SPI data, MSB first.
spi_cs  in  1  chip select, active low.
fifo_wr_en  out  1  FIFO write strobe, one cycle per word.
fifo_wdata  out  DATA_W+1  bit DATA_W = last flag, bits DATA_W-1:0 = data.
fifo_full  in  1  FIFO full.
fifo_rd_en  out  1  FIFO read strobe.
fifo_rdata  in  DATA_W+1  FIFO output, valid 1 cycle after fifo_rd_en.
fifo_empty  in  1  FIFO empty.
m_axis_tvalid  out  1  stream valid.
m_axis_tready  in  1  stream ready.
m_axis_tdata  out  DATA_W  stream data.
m_axis_tlast  out  1  last byte of the frame.
err_clr  in  1  one-cycle pulse; clears the sticky error flags.
overflow_err  out  1  sticky: a word was dropped because the FIFO was full.
frame_err  out  1  sticky: cs deasserted with a partial word.

Behaviour:
- Reset (async assert, sync release): all outputs 0, bit counter 0, staging register empty, drain FSM in IDLE.
- Synchronisation: each SPI pin passes through SYNC_STAGES flops. SCLK rising edge = synced sclk is 1 and its previous sample was 0. Frame start = synced cs falls; frame end = synced cs rises.
- Deserialiser: on a SCLK edge while synced cs is 0, shift mosi in MSB first and increment bit_cnt. At bit_cnt = DATA_W-1 the word is complete and bit_cnt wraps to 0.
- SCLK edges are ignored while cs is high. If a cs rise and a SCLK edge occur in the same cycle, the edge is ignored.
- Staging: a completed word is held in a staging register because its last flag is not yet known.
  - Word completes and staging is full: write the staged word with last=0, then load the new word into staging.
  - Frame end and staging is full: write the staged word with last=1 and empty the staging register.
  - Frame end and staging is empty: no write.
- Partial word at frame end (bit_cnt != 0): discard the partial bits, set frame_err, clear bit_cnt, and still flush staging with last=1.
- Frame start clears bit_cnt. A staging register that is still non-empty at frame start cannot occur, because frame end always flushes it.
- FIFO write: fifo_wr_en is pulsed for one cycle only if fifo_full=0. If fifo_full=1, the word is dropped, overflow_err is set, and no write occurs; the frame may then lack tlast.
- Drain FSM:
  - IDLE: if fifo_empty=0 and the output register is free (tvalid=0, or tvalid=1 and tready=1), pulse fifo_rd_en and go to FETCH.
  - FETCH: load fifo_rdata into tdata/tlast, set tvalid=1, return to IDLE.
  - Only one read is in flight at a time.
- AXI-Stream rules: tvalid, tdata and tlast are held stable until tready. tvalid drops after a handshake unless a new beat loads in the same cycle. Maximum throughput is one beat per 2 cycles, which far exceeds the SPI rate.
- Latency: from the SCLK edge of the final bit of a mid-frame word, that word appears on tvalid SYNC_STAGES+4 cycles after the next word completes.
- Errors: overflow_err and frame_err stay high until err_clr. If err_clr coincides with a new error event, the set wins.
- Reset mid-frame: the partial word and staged word are lost. No FIFO write, read or stream beat is issued until the first cs fall after reset release.

Decomposition:
- Shared package spi_pkg: DATA_W default, the last-flag bit index, and the drain state enum (IDLE, FETCH).
- One natural sub-module: spi_sync, a SYNC_STAGES-deep reset-to-0 synchroniser with rising/falling edge outputs, instantiated for sclk, mosi and cs (cs resets to 1).

Test Plan:
- Frame of bytes 0xA5, 0x3C at SCLK = aclk/8 -> fifo writes {0,A5}, {1,3C}; stream beats A5 (tlast=0), 3C (tlast=1).
- Single-byte frame 0x81 with tready held 0 for 20 cycles -> tvalid=1 and tdata=81, tlast=1 held stable until tready; exactly one beat.
- Frame of 12 bits (0xF0 followed by 4 bits) -> one beat F0 with tlast=1, frame_err=1; err_clr pulse -> frame_err=0.
- fifo_full forced to 1 during the second byte of a 3-byte frame -> overflow_err=1; stream carries bytes 1 and 3 only, byte 3 with tlast=1.
- axi_aresetn asserted after 5 bits of a byte, released, then a new frame with 0x55 -> no beat from the aborted frame; one beat 55 with tlast=1.
- cs toggles with no SCLK edges -> no fifo_wr_en, no beats, no errors.
